dcache_assoc_controller: RTL and testbench

DCACHE_ASSOC_CONTROLLER -- requirements
Module: dcache_assoc_controller

---
 rtl/dcache_assoc_controller_if.sv | 37 +++
 rtl/dcache_assoc_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_assoc_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_assoc_controller_if.sv
// CPU request/response, refill and eviction signals of the set-associative data cache.
// The master side (CPU/memory model) drives requests, fills and acks; the slave side is the cache.
interface dcache_assoc_controller_if #(
    parameter int ADDR_W          = 32,
    parameter int WORDS_PER_BLOCK = 8
);
    logic                            req_valid;
    logic                            req_we;
    logic [ADDR_W-1:0]               req_addr;
    logic [31:0]                     req_wdata;
    logic [3:0]                      req_wmask;
    logic                            req_ready;
    logic                            resp_valid;
    logic [31:0]                     resp_rdata;
    logic                            read_miss_repair;
    logic [ADDR_W-1:0]               missed_addr;
    logic                            repair_resolved;
    logic [32*WORDS_PER_BLOCK-1:0]   fill_data;
    logic                            evict_valid;
    logic [ADDR_W-1:0]               evict_addr;
    logic [32*WORDS_PER_BLOCK-1:0]   evict_data;
    logic                            evict_ack;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        output repair_resolved, fill_data, evict_ack,
        input  req_ready, resp_valid, resp_rdata, read_miss_repair, missed_addr,
        input  evict_valid, evict_addr, evict_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  repair_resolved, fill_data, evict_ack,
        output req_ready, resp_valid, resp_rdata, read_miss_repair, missed_addr,
        output evict_valid, evict_addr, evict_data
    );
endinterface

// File: rtl/dcache_assoc_controller.sv
// Blocking set-associative write-back data cache controller: one request in flight,
// lowest-invalid / round-robin replacement, dirty-victim eviction before refill.
module dcache_assoc_controller #(
    parameter int ADDR_W          = 32,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int NUM_SETS        = 16,
    parameter int NUM_WAYS        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dcache_assoc_controller_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int BLK_W = 32 * WORDS_PER_BLOCK;
    localparam int LOW_W = OFF_W + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        EVICT   = 3'd2,
        REFILL  = 3'd3,
        RESPOND = 3'd4
    } state_t;

    state_t state_r, state_n;

    logic [ADDR_W-3:0]   addr_r;
    logic                we_r;
    logic [31:0]         wdata_r;
    logic [3:0]          wmask_r;
    logic [WAY_W-1:0]    vic_way_r;

    logic [BLK_W-1:0]    data_mem [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_r  [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_r  [NUM_SETS];
    logic [WAY_W-1:0]    rr_r     [NUM_SETS];

    logic                req_ready_r, resp_valid_r, read_miss_repair_r, evict_valid_r;
    logic [31:0]         resp_rdata_r;
    logic [ADDR_W-1:0]   missed_addr_r, evict_addr_r;
    logic [BLK_W-1:0]    evict_data_r;

    logic [IDX_W-1:0]    idx_s;
    logic [OFF_W-1:0]    off_s;
    logic [TAG_W-1:0]    tag_s;
    logic [NUM_WAYS-1:0] hit_vec_s;
    logic                hit_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic                inv_found_s;
    logic [WAY_W-1:0]    inv_way_s;
    logic [WAY_W-1:0]    vic_way_s;
    logic [WAY_W-1:0]    vic_cur_s;
    logic                vic_dirty_s;
    logic [WAY_W-1:0]    rr_next_s;
    logic [31:0]         src_word_s;
    logic [31:0]         new_word_s;
    logic [BLK_W-1:0]    fill_blk_s;
    logic [ADDR_W-1:0]   missed_addr_n_s, evict_addr_n_s;
    logic [BLK_W-1:0]    evict_data_n_s;
    logic [31:0]         resp_rdata_n_s;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign idx_s = addr_r[OFF_W +: IDX_W];
    assign off_s = addr_r[OFF_W-1:0];
    assign tag_s = addr_r[ADDR_W-3 -: TAG_W];

    // Tag match, victim choice and the word a load/store completes with.
    always_comb begin
        hit_vec_s   = '0;
        hit_way_s   = '0;
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = valid_r[idx_s][w] && (tag_mem[idx_s][w] == tag_s);
        end
        hit_s = |hit_vec_s;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec_s[w]) begin
                hit_way_s = WAY_W'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
            if (!valid_r[idx_s][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_W'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        vic_way_s   = inv_found_s ? inv_way_s : rr_r[idx_s];
        vic_dirty_s = valid_r[idx_s][vic_way_s] && dirty_r[idx_s][vic_way_s];
        vic_cur_s   = (state_r == LOOKUP) ? vic_way_s : vic_way_r;
        rr_next_s   = (rr_r[idx_s] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_r[idx_s] + WAY_W'(1);
        // A hit completes from the stored line; a refill completes from the incoming block.
        src_word_s  = (state_r == LOOKUP) ? data_mem[idx_s][hit_way_s][32*off_s +: 32]
                                          : bus.fill_data[32*off_s +: 32];
        new_word_s  = we_r ? merge_word(src_word_s, wdata_r, wmask_r) : src_word_s;
        fill_blk_s  = bus.fill_data;
        fill_blk_s[32*off_s +: 32] = new_word_s;
    end

    // Next-state decision; handshakes outside their own state are ignored.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) state_n = LOOKUP;
                else               state_n = IDLE;
            end
            LOOKUP: begin
                if (hit_s)            state_n = RESPOND;
                else if (vic_dirty_s) state_n = EVICT;
                else                  state_n = REFILL;
            end
            EVICT: begin
                if (bus.evict_ack) state_n = REFILL;
                else               state_n = EVICT;
            end
            REFILL: begin
                if (bus.repair_resolved) state_n = RESPOND;
                else                     state_n = REFILL;
            end
            RESPOND: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output values for the state being entered, so every port comes straight from a flop.
    always_comb begin
        missed_addr_n_s = (state_n == REFILL) ? {tag_s, idx_s, {LOW_W{1'b0}}} : '0;
        evict_addr_n_s  = (state_n == EVICT)
                        ? {tag_mem[idx_s][vic_cur_s], idx_s, {LOW_W{1'b0}}} : '0;
        evict_data_n_s  = (state_n == EVICT) ? data_mem[idx_s][vic_cur_s] : '0;
        resp_rdata_n_s  = (state_n == RESPOND) ? new_word_s : 32'h0000_0000;
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r            <= IDLE;
            addr_r             <= '0;
            we_r               <= 1'b0;
            wdata_r            <= 32'h0000_0000;
            wmask_r            <= 4'h0;
            vic_way_r          <= '0;
            req_ready_r        <= 1'b1;
            resp_valid_r       <= 1'b0;
            read_miss_repair_r <= 1'b0;
            evict_valid_r      <= 1'b0;
            resp_rdata_r       <= 32'h0000_0000;
            missed_addr_r      <= '0;
            evict_addr_r       <= '0;
            evict_data_r       <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && bus.req_valid) begin
                addr_r  <= bus.req_addr[ADDR_W-1:2];
                we_r    <= bus.req_we;
                wdata_r <= bus.req_wdata;
                wmask_r <= bus.req_wmask;
            end
            vic_way_r          <= vic_cur_s;
            req_ready_r        <= (state_n == IDLE);
            resp_valid_r       <= (state_n == RESPOND);
            read_miss_repair_r <= (state_n == REFILL);
            evict_valid_r      <= (state_n == EVICT);
            resp_rdata_r       <= resp_rdata_n_s;
            missed_addr_r      <= missed_addr_n_s;
            evict_addr_r       <= evict_addr_n_s;
            evict_data_r       <= evict_data_n_s;
        end
    end

    // Line status: valid/dirty/round-robin, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                rr_r[s]    <= '0;
            end
        end else if (state_r == LOOKUP && hit_s && we_r) begin
            dirty_r[idx_s][hit_way_s] <= 1'b1;
        end else if (state_r == REFILL && bus.repair_resolved) begin
            valid_r[idx_s][vic_way_r] <= 1'b1;
            dirty_r[idx_s][vic_way_r] <= we_r;
            rr_r[idx_s]               <= rr_next_s;
        end
    end

    // Data and tag storage; never written while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && state_r == LOOKUP && hit_s && we_r) begin
            data_mem[idx_s][hit_way_s][32*off_s +: 32] <= new_word_s;
        end else if (rst && state_r == REFILL && bus.repair_resolved) begin
            data_mem[idx_s][vic_way_r] <= fill_blk_s;
            tag_mem[idx_s][vic_way_r]  <= tag_s;
        end
    end

    assign bus.req_ready        = req_ready_r;
    assign bus.resp_valid       = resp_valid_r;
    assign bus.resp_rdata       = resp_rdata_r;
    assign bus.read_miss_repair = read_miss_repair_r;
    assign bus.missed_addr      = missed_addr_r;
    assign bus.evict_valid      = evict_valid_r;
    assign bus.evict_addr       = evict_addr_r;
    assign bus.evict_data       = evict_data_r;
endmodule

// File: tb/tb_dcache_assoc_controller.sv
// Directed bench for dcache_assoc_controller (default parameters): vector table of
// single transactions plus hand-written eviction and mid-refill reset sequences.
module tb_dcache_assoc_controller;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [255:0] fill_pat;

    dcache_assoc_controller_if #(.ADDR_W(32), .WORDS_PER_BLOCK(8)) bus ();

    dcache_assoc_controller #(
        .ADDR_W(32), .WORDS_PER_BLOCK(8), .NUM_SETS(16), .NUM_WAYS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        miss;
        logic [31:0] maddr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request; a miss is served by a zero-wait fill of the standard pattern.
    task automatic do_req(input vec_t v, input int id);
        string tg;
        tg = $sformatf("v%0d", id);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_wmask = v.wmask;
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        chk({tg, "_ready_busy"}, {63'd0, bus.req_ready}, 64'd0);
        step();
        if (v.miss) begin
            chk({tg, "_miss_req"}, {63'd0, bus.read_miss_repair}, 64'd1);
            chk({tg, "_missed_addr"}, {32'd0, bus.missed_addr}, {32'd0, v.maddr});
            chk({tg, "_no_evict"}, {63'd0, bus.evict_valid}, 64'd0);
            chk({tg, "_no_early_resp"}, {63'd0, bus.resp_valid}, 64'd0);
            bus.repair_resolved = 1'b1;
            bus.fill_data       = fill_pat;
            step();
            bus.repair_resolved = 1'b0;
            chk({tg, "_repair_drop"}, {63'd0, bus.read_miss_repair}, 64'd0);
        end else begin
            chk({tg, "_hit_no_repair"}, {63'd0, bus.read_miss_repair}, 64'd0);
        end
        chk({tg, "_resp_valid"}, {63'd0, bus.resp_valid}, 64'd1);
        chk({tg, "_resp_rdata"}, {32'd0, bus.resp_rdata}, {32'd0, v.rdata});
        chk({tg, "_ready_busy2"}, {63'd0, bus.req_ready}, 64'd0);
        step();
        chk({tg, "_resp_once"}, {63'd0, bus.resp_valid}, 64'd0);
        chk({tg, "_ready_back"}, {63'd0, bus.req_ready}, 64'd1);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_req(vecs[i], i);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 8; i++) begin
            fill_pat[32*i +: 32] = 32'h1111_1111 * 32'(i);
        end
        //            we    addr           wdata          wmask miss  missed addr    rdata
        vecs[0]  = '{1'b0, 32'hAABB_CCDD, 32'h0,         4'h0, 1'b1, 32'hAABB_CCC0, 32'h7777_7777};
        vecs[1]  = '{1'b0, 32'hAABB_CCDD, 32'h0,         4'h0, 1'b0, 32'h0,         32'h7777_7777};
        vecs[2]  = '{1'b1, 32'hAABB_CCC4, 32'hDEAD_BEEF, 4'h3, 1'b0, 32'h0,         32'h1111_BEEF};
        vecs[3]  = '{1'b0, 32'hAABB_CCC4, 32'h0,         4'h0, 1'b0, 32'h0,         32'h1111_BEEF};
        vecs[4]  = '{1'b0, 32'hAABB_CCCC, 32'h0,         4'h0, 1'b0, 32'h0,         32'h3333_3333};
        vecs[5]  = '{1'b1, 32'hAABB_CCD0, 32'hCAFE_F00D, 4'hC, 1'b0, 32'h0,         32'hCAFE_4444};
        vecs[6]  = '{1'b0, 32'h0000_0CC8, 32'h0,         4'h0, 1'b1, 32'h0000_0CC0, 32'h2222_2222};
        vecs[7]  = '{1'b0, 32'h0000_0CC8, 32'h0,         4'h0, 1'b0, 32'h0,         32'h2222_2222};
        vecs[8]  = '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 1'b1, 32'h0000_1000, 32'h1111_1111};
        vecs[9]  = '{1'b1, 32'h0000_2008, 32'h1234_5678, 4'hF, 1'b1, 32'h0000_2000, 32'h1234_5678};
        vecs[10] = '{1'b0, 32'h0000_2008, 32'h0,         4'h0, 1'b0, 32'h0,         32'h1234_5678};
        vecs[11] = '{1'b0, 32'h0002_0CDC, 32'h0,         4'h0, 1'b1, 32'h0002_0CC0, 32'h7777_7777};
        vecs[12] = '{1'b0, 32'h0001_0CC4, 32'h0,         4'h0, 1'b0, 32'h0,         32'h1111_1111};
        vecs[13] = '{1'b0, 32'h0000_0CC8, 32'h0,         4'h0, 1'b1, 32'h0000_0CC0, 32'h2222_2222};
        vecs[14] = '{1'b0, 32'h0000_2008, 32'h0,         4'h0, 1'b1, 32'h0000_2000, 32'h2222_2222};
        vecs[15] = '{1'b0, 32'hAABB_CCDD, 32'h0,         4'h0, 1'b1, 32'hAABB_CCC0, 32'h7777_7777};

        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_wmask = 4'h0;
        bus.repair_resolved = 1'b0;
        bus.fill_data = '0;
        bus.evict_ack = 1'b0;
        rst = 1'b0;
        step();
        step();
        chk("rst_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_repair", {63'd0, bus.read_miss_repair}, 64'd0);
        chk("rst_evict_valid", {63'd0, bus.evict_valid}, 64'd0);
        chk("rst_missed_addr", {32'd0, bus.missed_addr}, 64'd0);
        chk("rst_evict_addr", {32'd0, bus.evict_addr}, 64'd0);
        chk("rst_evict_data_or", {63'd0, |bus.evict_data}, 64'd0);
        chk("rst_resp_rdata", {32'd0, bus.resp_rdata}, 64'd0);
        rst = 1'b1;
        step();
        chk("rel_ready", {63'd0, bus.req_ready}, 64'd1);

        run_range(0, 10);

        // Set 6 is full; round-robin picks way 0, the dirty 0xAABBCCC0 line.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0001_0CC0;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("ev_valid", {63'd0, bus.evict_valid}, 64'd1);
        chk("ev_addr", {32'd0, bus.evict_addr}, {32'd0, 32'hAABB_CCC0});
        chk("ev_word1", {32'd0, bus.evict_data[63:32]}, {32'd0, 32'h1111_BEEF});
        chk("ev_word4", {32'd0, bus.evict_data[159:128]}, {32'd0, 32'hCAFE_4444});
        chk("ev_word7", {32'd0, bus.evict_data[255:224]}, {32'd0, 32'h7777_7777});
        chk("ev_no_repair", {63'd0, bus.read_miss_repair}, 64'd0);
        bus.repair_resolved = 1'b1;
        bus.fill_data       = fill_pat;
        bus.req_valid       = 1'b1;
        bus.req_addr        = 32'h0000_2008;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("ev_hold%0d_valid", c), {63'd0, bus.evict_valid}, 64'd1);
            chk($sformatf("ev_hold%0d_repair", c), {63'd0, bus.read_miss_repair}, 64'd0);
            chk($sformatf("ev_hold%0d_resp", c), {63'd0, bus.resp_valid}, 64'd0);
            chk($sformatf("ev_hold%0d_ready", c), {63'd0, bus.req_ready}, 64'd0);
        end
        bus.repair_resolved = 1'b0;
        bus.req_valid       = 1'b0;
        bus.evict_ack       = 1'b1;
        step();
        bus.evict_ack = 1'b0;
        chk("ev_done_valid", {63'd0, bus.evict_valid}, 64'd0);
        chk("ev_refill_req", {63'd0, bus.read_miss_repair}, 64'd1);
        chk("ev_refill_addr", {32'd0, bus.missed_addr}, {32'd0, 32'h0001_0CC0});
        bus.repair_resolved = 1'b1;
        step();
        bus.repair_resolved = 1'b0;
        chk("ev_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
        chk("ev_resp_rdata", {32'd0, bus.resp_rdata}, 64'd0);
        step();
        chk("ev_idle_ready", {63'd0, bus.req_ready}, 64'd1);
        step();
        chk("ev_no_queued", {63'd0, bus.req_ready}, 64'd1);

        run_range(11, 13);

        // Reset while waiting for a refill; a fill offered on the reset edge must be dropped.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hAABB_CCDD;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("mr_refill_req", {63'd0, bus.read_miss_repair}, 64'd1);
        rst = 1'b0;
        bus.repair_resolved = 1'b1;
        step();
        bus.repair_resolved = 1'b0;
        chk("mr_repair_drop", {63'd0, bus.read_miss_repair}, 64'd0);
        chk("mr_missed_clear", {32'd0, bus.missed_addr}, 64'd0);
        chk("mr_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("mr_no_resp", {63'd0, bus.resp_valid}, 64'd0);
        rst = 1'b1;
        step();
        chk("mr_rel_ready", {63'd0, bus.req_ready}, 64'd1);

        run_range(14, 15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
